freg_file_sb: RTL and testbench

//  Next-generation floating-point register file: parametrised width/depth, 3 async read ports,
//  2 write-back ports (WB0 = single-cycle FP ALU, WB1 = multi-cycle div/sqrt/FMA unit) and a
//  per-register pending-write scoreboard. It sits between FP issue and FP execute. Issue marks a

---
 rtl/freg_file_sb.sv | 146 ++++++++++++++
 tb/tb_freg_file_sb.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freg_file_sb.sv
// freg_file_sb -- floating-point register file with pending-write scoreboard.
//
// Sits between FP issue and FP execute. Storage is DEPTH x WIDTH, every
// index (including 0) is a real register. Three combinational read ports,
// two write-back ports (WB0: single-cycle ALU, WB1: multi-cycle div/sqrt/FMA)
// and a per-register busy bit that issue sets and write-back clears.
//
// Optional build macro: FREG_BYPASS_EN
//   defined   : a write-back in flight is forwarded to matching read ports in
//               the same cycle (WB0 has priority) and the read-side busy flag
//               reads 0 for that index. Iss_Ready is never bypassed.
//   undefined : reads return stored data only; written data shows up the
//               cycle after the write edge, busy stays 1 during write-back.
//
// Ports
//   CLK, RST             clock (rising edge), asynchronous active-high reset
//   Rs{1,2,3}_rd         read indices
//   Rs{1,2,3}_Out        read data
//   Rs{1,2,3}_Busy       pending write on the read index
//   Iss_Valid, Iss_Rd    issue request and its destination
//   Iss_Ready            destination not busy, issue may proceed
//   Wb{0,1}_En/_Rd/_Data write-back ports
//   Busy_Cnt             number of registers currently busy (0..DEPTH)
//   Wb_Collision         sticky: both write-back ports hit one index together
//
// Issue handshake: an issue is accepted on a rising edge where
// Iss_Valid && Iss_Ready. Iss_Ready depends only on registered busy state
// and Iss_Rd (never on Iss_Valid); a requester may hold Iss_Valid until
// accepted. An accepted issue marks Iss_Rd busy from the next cycle on.

module freg_file_sb #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] Rs1_rd,
  input  logic [ADDR_W-1:0] Rs2_rd,
  input  logic [ADDR_W-1:0] Rs3_rd,
  output logic [WIDTH-1:0]  Rs1_Out,
  output logic [WIDTH-1:0]  Rs2_Out,
  output logic [WIDTH-1:0]  Rs3_Out,
  output logic              Rs1_Busy,
  output logic              Rs2_Busy,
  output logic              Rs3_Busy,
  input  logic              Iss_Valid,
  input  logic [ADDR_W-1:0] Iss_Rd,
  output logic              Iss_Ready,
  input  logic              Wb0_En,
  input  logic [ADDR_W-1:0] Wb0_Rd,
  input  logic [WIDTH-1:0]  Wb0_Data,
  input  logic              Wb1_En,
  input  logic [ADDR_W-1:0] Wb1_Rd,
  input  logic [WIDTH-1:0]  Wb1_Data,
  output logic [ADDR_W:0]   Busy_Cnt,
  output logic              Wb_Collision
);

  localparam int CNT_W = ADDR_W + 1;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              iss_acc;
  logic              same_idx;
  logic              clr0;
  logic              clr1;

  logic [ADDR_W-1:0] rd_idx  [3];
  logic [WIDTH-1:0]  rd_out  [3];
  logic              rd_busy [3];

  assign same_idx  = Wb0_En && Wb1_En && (Wb0_Rd == Wb1_Rd);
  assign Iss_Ready = !busy[Iss_Rd];
  assign iss_acc   = Iss_Valid && Iss_Ready;

  // A busy bit is counted as cleared only if it was set; when both ports
  // hit the same busy index it is one clear, credited to WB0.
  assign clr0 = Wb0_En && busy[Wb0_Rd];
  assign clr1 = Wb1_En && busy[Wb1_Rd] && !same_idx;

  // Clears are applied before the set so that an issue to a non-busy index
  // that is also being written back still ends up busy.
  always_comb begin
    busy_nxt = busy;
    if (Wb0_En)  busy_nxt[Wb0_Rd] = 1'b0;
    if (Wb1_En)  busy_nxt[Wb1_Rd] = 1'b0;
    if (iss_acc) busy_nxt[Iss_Rd] = 1'b1;
  end

  assign cnt_nxt = Busy_Cnt + CNT_W'(iss_acc) - CNT_W'(clr0) - CNT_W'(clr1);

  // Register storage. WB0 is assigned last so it wins on a shared index.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (Wb1_En) mem[Wb1_Rd] <= Wb1_Data;
      if (Wb0_En) mem[Wb0_Rd] <= Wb0_Data;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      busy         <= '0;
      Busy_Cnt     <= '0;
      Wb_Collision <= 1'b0;
    end else begin
      busy     <= busy_nxt;
      Busy_Cnt <= cnt_nxt;
      if (same_idx) Wb_Collision <= 1'b1;
    end
  end

  assign rd_idx[0] = Rs1_rd;
  assign rd_idx[1] = Rs2_rd;
  assign rd_idx[2] = Rs3_rd;

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rd_out[p]  = mem[rd_idx[p]];
      rd_busy[p] = busy[rd_idx[p]];
`ifdef FREG_BYPASS_EN
      // WB1 first, then WB0 overrides it: WB0 has forwarding priority.
      if (Wb1_En && (Wb1_Rd == rd_idx[p])) begin
        rd_out[p]  = Wb1_Data;
        rd_busy[p] = 1'b0;
      end
      if (Wb0_En && (Wb0_Rd == rd_idx[p])) begin
        rd_out[p]  = Wb0_Data;
        rd_busy[p] = 1'b0;
      end
`endif
    end
  end

  assign Rs1_Out  = rd_out[0];
  assign Rs2_Out  = rd_out[1];
  assign Rs3_Out  = rd_out[2];
  assign Rs1_Busy = rd_busy[0];
  assign Rs2_Busy = rd_busy[1];
  assign Rs3_Busy = rd_busy[2];

endmodule

// File: tb/tb_freg_file_sb.sv
// Testbench for freg_file_sb (WIDTH=32, DEPTH=32). Directed table, hand
// sequences for collision / bypass / full scoreboard / mid-run reset, then
// randomized traffic against a behavioural model.

module tb_freg_file_sb;

  localparam int W = 32;
  localparam int D = 32;
  localparam int A = 5;
`ifdef FREG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [A-1:0] rs1_rd = '0, rs2_rd = '0, rs3_rd = '0;
  logic [W-1:0] rs1_out, rs2_out, rs3_out;
  logic         rs1_busy, rs2_busy, rs3_busy;
  logic         iss_valid = 1'b0;
  logic [A-1:0] iss_rd = '0;
  logic         iss_ready;
  logic         wb0_en = 1'b0, wb1_en = 1'b0;
  logic [A-1:0] wb0_rd = '0, wb1_rd = '0;
  logic [W-1:0] wb0_data = '0, wb1_data = '0;
  logic [A:0]   busy_cnt;
  logic         wb_collision;

  always #5 clk = ~clk;

  freg_file_sb #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK(clk), .RST(rst),
    .Rs1_rd(rs1_rd), .Rs2_rd(rs2_rd), .Rs3_rd(rs3_rd),
    .Rs1_Out(rs1_out), .Rs2_Out(rs2_out), .Rs3_Out(rs3_out),
    .Rs1_Busy(rs1_busy), .Rs2_Busy(rs2_busy), .Rs3_Busy(rs3_busy),
    .Iss_Valid(iss_valid), .Iss_Rd(iss_rd), .Iss_Ready(iss_ready),
    .Wb0_En(wb0_en), .Wb0_Rd(wb0_rd), .Wb0_Data(wb0_data),
    .Wb1_En(wb1_en), .Wb1_Rd(wb1_rd), .Wb1_Data(wb1_data),
    .Busy_Cnt(busy_cnt), .Wb_Collision(wb_collision)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    iss_valid = 1'b0; wb0_en = 1'b0; wb1_en = 1'b0;
  endtask

  task automatic drive(input logic iv, input logic [A-1:0] ird,
                       input logic w0e, input logic [A-1:0] w0r, input logic [W-1:0] w0d,
                       input logic w1e, input logic [A-1:0] w1r, input logic [W-1:0] w1d);
    iss_valid = iv; iss_rd = ird;
    wb0_en = w0e; wb0_rd = w0r; wb0_data = w0d;
    wb1_en = w1e; wb1_rd = w1r; wb1_data = w1d;
  endtask

  // Let the current inputs take effect on one rising edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic         iv;  logic [A-1:0] ird;
    logic         w0e; logic [A-1:0] w0r; logic [W-1:0] w0d;
    logic         w1e; logic [A-1:0] w1r; logic [W-1:0] w1d;
    logic [A-1:0] r1;  logic [A-1:0] r2;
    logic         exp_ready;   // Iss_Ready while the vector is applied
    logic [W-1:0] exp_r1;      // Rs1_Out in the following idle cycle
    logic         exp_b2;      // Rs2_Busy in the following idle cycle
    logic [A:0]   exp_cnt;     // Busy_Cnt in the following idle cycle
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(logic iv, logic [A-1:0] ird,
                              logic w0e, logic [A-1:0] w0r, logic [W-1:0] w0d,
                              logic w1e, logic [A-1:0] w1r, logic [W-1:0] w1d,
                              logic [A-1:0] r1, logic [A-1:0] r2,
                              logic er, logic [W-1:0] e1, logic eb2, logic [A:0] ec);
    vec_t v;
    v.iv = iv; v.ird = ird; v.w0e = w0e; v.w0r = w0r; v.w0d = w0d;
    v.w1e = w1e; v.w1r = w1r; v.w1d = w1d; v.r1 = r1; v.r2 = r2;
    v.exp_ready = er; v.exp_r1 = e1; v.exp_b2 = eb2; v.exp_cnt = ec;
    return v;
  endfunction

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_mem [D];
  bit           m_busy [D];
  bit           m_coll;

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < D; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  function automatic logic [W-1:0] m_read(input logic [A-1:0] a);
    logic [W-1:0] v = m_mem[a];
    if (BYP && wb1_en && wb1_rd == a) v = wb1_data;
    if (BYP && wb0_en && wb0_rd == a) v = wb0_data;
    return v;
  endfunction

  function automatic logic m_rbusy(input logic [A-1:0] a);
    if (BYP && ((wb0_en && wb0_rd == a) || (wb1_en && wb1_rd == a))) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic m_clear();
    for (int i = 0; i < D; i++) begin m_mem[i] = '0; m_busy[i] = 0; end
    m_coll = 0;
  endtask

  // Architectural effect of one clock edge with the currently driven inputs.
  task automatic m_step();
    bit acc = iss_valid && !m_busy[iss_rd];
    if (wb1_en) begin m_mem[wb1_rd] = wb1_data; m_busy[wb1_rd] = 0; end
    if (wb0_en) begin m_mem[wb0_rd] = wb0_data; m_busy[wb0_rd] = 0; end
    if (wb0_en && wb1_en && wb0_rd == wb1_rd) m_coll = 1;
    if (acc) m_busy[iss_rd] = 1;
  endtask

  task automatic rand_cycle();
    logic [A-1:0] hot;
    hot = A'($urandom_range(0, 7));
    iss_valid = 1'($urandom_range(0, 1));
    iss_rd    = ($urandom_range(0, 3) != 0) ? A'($urandom_range(0, 7)) : A'($urandom_range(0, D-1));
    wb0_en    = 1'($urandom_range(0, 1));
    wb0_rd    = ($urandom_range(0, 3) != 0) ? A'($urandom_range(0, 7)) : A'($urandom_range(0, D-1));
    wb0_data  = W'($urandom);
    wb1_en    = ($urandom_range(0, 2) == 0);
    wb1_rd    = ($urandom_range(0, 15) == 0) ? wb0_rd : A'($urandom_range(0, 7));
    wb1_data  = W'($urandom);
    rs1_rd    = ($urandom_range(0, 1) != 0) ? wb0_rd : hot;
    rs2_rd    = ($urandom_range(0, 1) != 0) ? wb1_rd : A'($urandom_range(0, D-1));
    rs3_rd    = A'($urandom_range(0, 7));
    @(negedge clk);
    exp_q.push_back(m_read(rs1_rd));
    exp_q.push_back(m_read(rs2_rd));
    exp_q.push_back(m_read(rs3_rd));
    chk("rnd_rs1_out", rs1_out, exp_q.pop_front());
    chk("rnd_rs2_out", rs2_out, exp_q.pop_front());
    chk("rnd_rs3_out", rs3_out, exp_q.pop_front());
    chk("rnd_rs1_busy", W'(rs1_busy), W'(m_rbusy(rs1_rd)));
    chk("rnd_rs2_busy", W'(rs2_busy), W'(m_rbusy(rs2_rd)));
    chk("rnd_rs3_busy", W'(rs3_busy), W'(m_rbusy(rs3_rd)));
    chk("rnd_iss_ready", W'(iss_ready), W'(!m_busy[iss_rd]));
    chk("rnd_busy_cnt", W'(busy_cnt), W'(m_count()));
    chk("rnd_collision", W'(wb_collision), W'(m_coll));
    @(posedge clk);
    m_step();
    #1;
  endtask

  // ---------------- test ----------------
  initial begin
    tbl[0]  = mk(0, 0,  1, 5,  32'h3F80_0000, 0, 0,  0,            5,  5,  1, 32'h3F80_0000, 0, 0);
    tbl[1]  = mk(0, 0,  1, 0,  32'h4000_0000, 0, 0,  0,            0,  0,  1, 32'h4000_0000, 0, 0);
    tbl[2]  = mk(1, 7,  0, 0,  0,             0, 0,  0,            5,  7,  1, 32'h3F80_0000, 1, 1);
    tbl[3]  = mk(1, 7,  0, 0,  0,             0, 0,  0,            5,  7,  0, 32'h3F80_0000, 1, 1);
    tbl[4]  = mk(0, 7,  0, 0,  0,             1, 7,  32'hC049_0FDB, 7,  7,  0, 32'hC049_0FDB, 0, 0);
    tbl[5]  = mk(1, 3,  0, 0,  0,             0, 0,  0,            7,  3,  1, 32'hC049_0FDB, 1, 1);
    tbl[6]  = mk(1, 9,  0, 0,  0,             0, 0,  0,            7,  9,  1, 32'hC049_0FDB, 1, 2);
    tbl[7]  = mk(1, 12, 1, 3,  32'h0000_0033, 1, 9,  32'h0000_0099, 3,  12, 1, 32'h0000_0033, 1, 1);
    tbl[8]  = mk(0, 12, 1, 12, 32'h0000_0012, 0, 0,  0,            12, 12, 0, 32'h0000_0012, 0, 0);
    tbl[9]  = mk(0, 0,  1, 20, 32'h0000_0055, 0, 0,  0,            20, 20, 1, 32'h0000_0055, 0, 0);
    tbl[10] = mk(1, 15, 1, 15, 32'h0000_0077, 0, 0,  0,            15, 15, 1, 32'h0000_0077, 1, 1);
    tbl[11] = mk(0, 0,  0, 0,  0,             1, 15, 32'h0000_0078, 15, 15, 1, 32'h0000_0078, 0, 0);

    do_reset();

    // Reset state
    rs1_rd = 5; rs2_rd = 0; rs3_rd = 31; iss_rd = 7;
    @(negedge clk);
    chk("rst_rs1_out", rs1_out, 32'h0);
    chk("rst_rs3_busy", W'(rs3_busy), 32'h0);
    chk("rst_busy_cnt", W'(busy_cnt), 32'h0);
    chk("rst_iss_ready", W'(iss_ready), 32'h1);
    chk("rst_collision", W'(wb_collision), 32'h0);
    @(posedge clk); #1;

    // Directed table: apply vector for one edge, then read back in an idle cycle
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].iv, tbl[i].ird, tbl[i].w0e, tbl[i].w0r, tbl[i].w0d,
            tbl[i].w1e, tbl[i].w1r, tbl[i].w1d);
      rs1_rd = tbl[i].r1; rs2_rd = tbl[i].r2; rs3_rd = 0;
      @(negedge clk);
      chk($sformatf("tbl%0d_iss_ready", i), W'(iss_ready), W'(tbl[i].exp_ready));
      tick();
      set_idle();
      @(negedge clk);
      chk($sformatf("tbl%0d_rs1_out", i), rs1_out, tbl[i].exp_r1);
      chk($sformatf("tbl%0d_rs2_busy", i), W'(rs2_busy), W'(tbl[i].exp_b2));
      chk($sformatf("tbl%0d_busy_cnt", i), W'(busy_cnt), W'(tbl[i].exp_cnt));
      tick();
    end

    // Same-index write-back from both ports onto a busy register
    drive(1, 4, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 1, 4, 32'h1111, 1, 4, 32'h2222);
    rs1_rd = 4;
    tick();
    set_idle();
    @(negedge clk);
    chk("coll_rs1_out", rs1_out, 32'h1111);
    chk("coll_flag", W'(wb_collision), 32'h1);
    chk("coll_busy_cnt", W'(busy_cnt), 32'h0);
    chk("coll_rs1_busy", W'(rs1_busy), 32'h0);
    repeat (3) tick();
    @(negedge clk);
    chk("coll_sticky", W'(wb_collision), 32'h1);
    tick();

    // Forwarding: write-back to a busy register read in the same cycle
    drive(0, 0, 1, 6, 32'h1234, 0, 0, 0);
    tick();
    drive(1, 6, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 6, 1, 6, 32'hABCD, 0, 0, 0);
    rs3_rd = 6;
    @(negedge clk);
    chk("byp_rs3_out", rs3_out, BYP ? 32'hABCD : 32'h1234);
    chk("byp_rs3_busy", W'(rs3_busy), BYP ? 32'h0 : 32'h1);
    chk("byp_iss_ready", W'(iss_ready), 32'h0);
    tick();
    set_idle();
    @(negedge clk);
    chk("byp_after_rs3_out", rs3_out, 32'hABCD);
    chk("byp_after_rs3_busy", W'(rs3_busy), 32'h0);
    tick();

    // Fill the scoreboard: Busy_Cnt reaches DEPTH and saturates there
    for (int i = 0; i < D; i++) begin
      drive(1, A'(i), 0, 0, 0, 0, 0, 0);
      tick();
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("full_iss_ready", W'(iss_ready), 32'h0);
    tick();
    set_idle();
    @(negedge clk);
    chk("full_busy_cnt", W'(busy_cnt), 32'd32);

    // Asynchronous reset mid-run, asserted away from any clock edge
    rs1_rd = 5; rs2_rd = 0; rs3_rd = 4; iss_rd = 2;
    #2 rst = 1'b1;
    #1;
    chk("arst_rs1_out", rs1_out, 32'h0);
    chk("arst_rs2_out", rs2_out, 32'h0);
    chk("arst_rs3_out", rs3_out, 32'h0);
    chk("arst_rs3_busy", W'(rs3_busy), 32'h0);
    chk("arst_busy_cnt", W'(busy_cnt), 32'h0);
    chk("arst_iss_ready", W'(iss_ready), 32'h1);
    chk("arst_collision", W'(wb_collision), 32'h0);
    tick();
    rst = 1'b0;
    // Late write-back after reset is a plain write
    drive(0, 0, 0, 0, 0, 1, 7, 32'h99);
    rs1_rd = 7;
    tick();
    set_idle();
    @(negedge clk);
    chk("late_wb_rs1_out", rs1_out, 32'h99);
    chk("late_wb_busy_cnt", W'(busy_cnt), 32'h0);
    chk("late_wb_ready", W'(iss_ready), 32'h1);
    tick();

    // Randomized traffic against the model
    do_reset();
    m_clear();
    for (int n = 0; n < 1500; n++) rand_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
